bayer_multi_row_buffer: RTL and testbench

BAYER_MULTI_ROW_BUFFER -- requirements
Module: bayer_multi_row_buffer

---
 rtl/bayer_multi_row_buffer.sv | 138 +++++++++++++
 tb/tb_bayer_multi_row_buffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_multi_row_buffer.sv
`default_nettype none
// ============================================================================
// Module  : bayer_multi_row_buffer
// Purpose : Line buffer presenting NUM_TAPS vertically aligned Bayer pixels.
// Revision: 1.0 - initial release
// ============================================================================
module bayer_multi_row_buffer #(
  parameter int DATA_W    = 12,
  parameter int MAX_WIDTH = 1280,
  parameter int NUM_TAPS  = 3,
  parameter int ADDR_W    = 11
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       iFVAL,
  input  logic                       iDVAL,
  input  logic [DATA_W-1:0]          iDATA,
  input  logic [ADDR_W:0]            iLINE_LEN,
  output logic [NUM_TAPS*DATA_W-1:0] oTAPS,
  output logic                       oDVAL,
  output logic [ADDR_W-1:0]          oCOL,
  output logic [11:0]                oROW,
  output logic                       oFULL,
  output logic                       oCFG_ERR
);

  localparam int HIST   = NUM_TAPS - 1;
  localparam int FILL_W = 3;
  localparam logic [ADDR_W:0]   c_MAX_LEN  = (ADDR_W+1)'(MAX_WIDTH);
  localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(HIST);
  localparam logic [11:0]       c_ROW_MAX  = 12'hFFF;

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                     r_state;
  logic                       r_fvalD;
  logic [ADDR_W:0]            r_len;
  logic [ADDR_W-1:0]          r_col;
  logic [11:0]                r_row;
  logic [FILL_W-1:0]          r_filled;
  logic [NUM_TAPS*DATA_W-1:0] r_taps;
  logic                       r_dval;
  logic [ADDR_W-1:0]          r_outCol;
  logic [11:0]                r_outRow;
  logic                       r_full;
  logic                       r_cfgErr;

  logic                       w_start;
  logic                       w_lenOk;
  logic                       w_accept;
  logic [ADDR_W:0]            w_len;
  logic [ADDR_W-1:0]          w_col;
  logic [11:0]                w_row;
  logic [FILL_W-1:0]          w_filled;
  logic                       w_lastCol;
  logic [HIST:0][DATA_W-1:0]  w_rd;
  logic [NUM_TAPS*DATA_W-1:0] w_tapNext;

  // The start-edge cycle sees freshly cleared counters so its pixel lands at column 0.
  assign w_start   = (r_state == IDLE) && iFVAL && !r_fvalD;
  assign w_lenOk   = (iLINE_LEN != '0) && (iLINE_LEN <= c_MAX_LEN);
  assign w_accept  = iDVAL && iFVAL && ((r_state == ACTIVE) || w_start);
  assign w_len     = w_start ? (w_lenOk ? iLINE_LEN : c_MAX_LEN) : r_len;
  assign w_col     = w_start ? '0 : r_col;
  assign w_row     = w_start ? '0 : r_row;
  assign w_filled  = w_start ? '0 : r_filled;
  assign w_lastCol = ({1'b0, w_col} == (w_len - 1'b1));
  assign w_rd[0]   = iDATA;

  // Each history row shifts down one RAM per accepted pixel, read-before-write.
  for (genvar k = 1; k <= HIST; k++) begin : g_ram
    logic [DATA_W-1:0] r_mem [MAX_WIDTH];
    assign w_rd[k] = r_mem[w_col];
    always_ff @(posedge iCLK) begin
      if (w_accept) r_mem[w_col] <= w_rd[k-1];
    end
  end

  // Rows not yet refilled in this frame are shown as zero.
  for (genvar k = 0; k <= HIST; k++) begin : g_tap
    assign w_tapNext[k*DATA_W +: DATA_W] =
      ((k == 0) || (FILL_W'(k) <= w_filled)) ? w_rd[k] : '0;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state  <= IDLE;
      r_fvalD  <= 1'b0;
      r_len    <= c_MAX_LEN;
      r_col    <= '0;
      r_row    <= '0;
      r_filled <= '0;
      r_taps   <= '0;
      r_dval   <= 1'b0;
      r_outCol <= '0;
      r_outRow <= '0;
      r_full   <= 1'b0;
      r_cfgErr <= 1'b0;
    end else begin
      r_fvalD  <= iFVAL;
      r_cfgErr <= w_start && !w_lenOk;
      r_dval   <= w_accept;
      case (r_state)
        IDLE:    if (w_start) r_state <= ACTIVE;
        ACTIVE:  if (!iFVAL) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_start) begin
        r_len    <= w_len;
        r_col    <= '0;
        r_row    <= '0;
        r_filled <= '0;
      end
      if (w_accept) begin
        r_taps   <= w_tapNext;
        r_outCol <= w_col;
        r_outRow <= w_row;
        r_full   <= (w_filled == c_FILL_MAX);
        if (w_lastCol) begin
          r_col    <= '0;
          r_row    <= (w_row == c_ROW_MAX) ? w_row : w_row + 12'd1;
          r_filled <= (w_filled == c_FILL_MAX) ? w_filled : w_filled + 1'b1;
        end else begin
          r_col    <= w_col + 1'b1;
        end
      end
    end
  end

  assign oTAPS    = r_taps;
  assign oDVAL    = r_dval;
  assign oCOL     = r_outCol;
  assign oROW     = r_outRow;
  assign oFULL    = r_full;
  assign oCFG_ERR = r_cfgErr;

endmodule
`default_nettype wire

// File: tb/tb_bayer_multi_row_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bayer_multi_row_buffer
// Purpose : Self-checking bench for bayer_multi_row_buffer against a frame model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bayer_multi_row_buffer;

  localparam int DW = 12;
  localparam int MW = 8;
  localparam int NT = 3;
  localparam int AW = 3;

  logic             clk  = 1'b0;
  logic             rstN = 1'b1;
  logic             fval = 1'b0;
  logic             dval = 1'b0;
  logic [DW-1:0]    data = '0;
  logic [AW:0]      len  = '0;
  logic [NT*DW-1:0] oTAPS;
  logic             oDVAL;
  logic [AW-1:0]    oCOL;
  logic [11:0]      oROW;
  logic             oFULL;
  logic             oCFG_ERR;

  bayer_multi_row_buffer #(.DATA_W(DW), .MAX_WIDTH(MW), .NUM_TAPS(NT), .ADDR_W(AW)) dut (
    .iCLK(clk), .iRST(rstN), .iFVAL(fval), .iDVAL(dval), .iDATA(data),
    .iLINE_LEN(len), .oTAPS(oTAPS), .oDVAL(oDVAL), .oCOL(oCOL), .oROW(oROW),
    .oFULL(oFULL), .oCFG_ERR(oCFG_ERR)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;

  // Frame model: pixels of the current frame kept in arrival order.
  bit mActive, mPrevF;
  int mL, mN;
  int mFr[$];
  logic             eD, eF, eE;
  logic [NT*DW-1:0] eT;
  logic [AW-1:0]    eC;
  logic [11:0]      eR;

  function automatic void modelReset();
    mActive = 0; mPrevF = 0; mL = MW; mN = 0; mFr.delete();
    eD = 0; eF = 0; eE = 0; eT = '0; eC = '0; eR = '0;
  endfunction

  task automatic step(input bit f, input bit d, input int px, input int ln);
    bit st, acc, ok;
    int row;
    @(negedge clk);
    fval = f; dval = d; data = DW'(px); len = (AW+1)'(ln);
    ok  = (ln >= 1) && (ln <= MW);
    st  = !mActive && f && !mPrevF;
    acc = d && f && (mActive || st);
    eE  = st && !ok;
    if (st) begin mL = ok ? ln : MW; mN = 0; mFr.delete(); end
    eD = acc;
    if (acc) begin
      row = mN / mL;
      eC  = AW'(mN % mL);
      eR  = (row > 4095) ? 12'd4095 : 12'(row);
      eF  = (row >= NT-1);
      for (int k = 0; k < NT; k++)
        eT[k*DW +: DW] = (k == 0) ? DW'(px) : ((k <= row) ? DW'(mFr[mN - k*mL]) : '0);
      mFr.push_back(px);
      mN++;
    end
    if (st) mActive = 1;
    else if (mActive && !f) mActive = 0;
    mPrevF = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nCmp++;
    if ({oTAPS, oDVAL, oCOL, oROW, oFULL, oCFG_ERR} !== '0) begin
      nErr++;
      $display("FAIL reset: got %h want 0", {oTAPS, oDVAL, oCOL, oROW, oFULL, oCFG_ERR});
    end
    @(negedge clk) rstN = 1'b1;
    modelReset();
  endtask

  task automatic test_idle_dval();
    for (int i = 0; i < 10; i++) begin
      step(0, 1, int'($urandom_range(4095)), 4);
      nCmp++;
      if (oDVAL !== 1'b0 || oCOL !== '0) begin
        nErr++;
        $display("FAIL idle_dval cyc%0d: got dval=%b col=%0d want dval=0 col=0", i, oDVAL, oCOL);
      end
    end
  endtask

  task automatic test_continuous();
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, i, 4);
      nCmp++;
      if ({oDVAL, oTAPS, oCOL, oROW, oFULL, oCFG_ERR} !== {eD, eT, eC, eR, eF, eE}) begin
        nErr++;
        $display("FAIL cont px%0d: got %h want %h", i,
                 {oDVAL, oTAPS, oCOL, oROW, oFULL, oCFG_ERR}, {eD, eT, eC, eR, eF, eE});
      end
      if (i == 5 || i == 9 || i == 12) begin
        nCmp++;
        if ((i == 5  && oTAPS !== {12'd0, 12'd1, 12'd5}) ||
            (i == 9  && (oTAPS !== {12'd1, 12'd5, 12'd9} || oFULL !== 1'b1)) ||
            (i == 12 && (oCOL !== 3'd3 || oROW !== 12'd2))) begin
          nErr++;
          $display("FAIL cont_fixed px%0d: got taps=%h full=%b col=%0d row=%0d", i, oTAPS, oFULL, oCOL, oROW);
        end
      end
    end
    step(0, 0, 0, 4);
  endtask

  task automatic test_gaps();
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, i, 4);
      nCmp++;
      if ({oDVAL, oTAPS, oCOL, oROW, oFULL} !== {1'b1, eT, eC, eR, eF}) begin
        nErr++;
        $display("FAIL gaps px%0d: got %h want %h", i, {oDVAL, oTAPS, oCOL, oROW, oFULL}, {1'b1, eT, eC, eR, eF});
      end
      if ((i == 5 && oTAPS !== {12'd0, 12'd1, 12'd5}) || (i == 9 && oTAPS !== {12'd1, 12'd5, 12'd9})) begin
        nErr++;
        $display("FAIL gaps_fixed px%0d: got taps=%h", i, oTAPS);
      end
      for (int g = 0; g < 2; g++) begin
        step(1, 0, int'($urandom_range(4095)), int'($urandom_range(15)));
        nCmp++;
        if ({oDVAL, oTAPS, oCOL, oROW, oFULL} !== {1'b0, eT, eC, eR, eF}) begin
          nErr++;
          $display("FAIL gaps_hold px%0d: got %h want %h", i, {oDVAL, oTAPS, oCOL, oROW, oFULL}, {1'b0, eT, eC, eR, eF});
        end
      end
    end
    step(0, 0, 0, 4);
  endtask

  task automatic test_cfg_err();
    int lens[2] = '{0, 9};
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 10; i++) begin
        step(1, 1, int'($urandom_range(4095)), lens[f]);
        nCmp++;
        if ({oDVAL, oTAPS, oCOL, oROW, oFULL, oCFG_ERR} !== {eD, eT, eC, eR, eF, eE} ||
            oCFG_ERR !== (i == 0) || (i == 8 && (oCOL !== 3'd0 || oROW !== 12'd1))) begin
          nErr++;
          $display("FAIL cfg_err len%0d px%0d: got err=%b col=%0d row=%0d want err=%b",
                   lens[f], i, oCFG_ERR, oCOL, oROW, eE);
        end
      end
      step(0, 0, 0, 4);
    end
  endtask

  task automatic test_stale();
    for (int i = 0; i < 12; i++) step(1, 1, int'($urandom_range(4095)), 4);
    step(0, 0, 0, 4);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 100 + i, 4);
      nCmp++;
      if ({oDVAL, oTAPS, oCOL, oROW, oFULL, oCFG_ERR} !== {eD, eT, eC, eR, eF, eE} ||
          (i < 4 && (oTAPS[2*DW-1:0] !== {12'd0, 12'(100 + i)} || oTAPS[3*DW-1:2*DW] !== '0 || oFULL !== 1'b0))) begin
        nErr++;
        $display("FAIL stale px%0d: got taps=%h full=%b want taps=%h full=%b", i, oTAPS, oFULL, eT, eF);
      end
    end
    step(0, 0, 0, 4);
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 5; i++) step(1, 1, i, 4);
    @(negedge clk);
    fval = 1'b1; dval = 1'b1; data = 12'd6;
    #2 rstN = 1'b0;
    #1;
    nCmp++;
    if ({oTAPS, oDVAL, oCOL, oROW, oFULL, oCFG_ERR} !== '0) begin
      nErr++;
      $display("FAIL reset_mid_async: got %h want 0", {oTAPS, oDVAL, oCOL, oROW, oFULL, oCFG_ERR});
    end
    fval = 1'b0; dval = 1'b0;
    @(negedge clk) rstN = 1'b1;
    modelReset();
    step(0, 0, 0, 4);
    step(1, 1, 1, 4);
    nCmp++;
    if (oTAPS !== {12'd0, 12'd0, 12'd1} || oROW !== 12'd0 || oDVAL !== 1'b1 ||
        {oTAPS, oCOL, oROW, oFULL} !== {eT, eC, eR, eF}) begin
      nErr++;
      $display("FAIL reset_mid_next: got taps=%h row=%0d dval=%b want taps=%h row=0 dval=1", oTAPS, oROW, oDVAL, eT);
    end
    step(0, 0, 0, 4);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int ln, n;
      ln = int'($urandom_range(10));
      n  = int'($urandom_range(40, 5));
      for (int i = 0; i < n; i++) begin
        step(1, (i == 0) ? 1'b1 : 1'($urandom_range(1)), int'($urandom_range(4095)), ln);
        nCmp++;
        if ({oDVAL, oTAPS, oCOL, oROW, oFULL, oCFG_ERR} !== {eD, eT, eC, eR, eF, eE}) begin
          nErr++;
          $display("FAIL random f%0d c%0d: got %h want %h", f, i,
                   {oDVAL, oTAPS, oCOL, oROW, oFULL, oCFG_ERR}, {eD, eT, eC, eR, eF, eE});
        end
        ln = int'($urandom_range(10));
      end
      step(0, 0, 0, 4);
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_idle_dval();
    test_continuous();
    test_gaps();
    test_cfg_err();
    test_stale();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
`default_nettype wire
